plle2_drp_sequencer: RTL

- Reconfigures a PLLE2 through its DRP port from a table of read-modify-write entries, then releases the PLL and waits for lock.
- Sits between the PLL test harness (start/status to switches/LEDs) and the PLLE2 primitive. DCLK is tied to CLK.
- Holds the PLL in reset during reprogramming; flags DRP or lock timeouts.

---
 rtl/plle2_drp_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/plle2_drp_sequencer.sv
// PLLE2 DRP reconfiguration sequencer: table-driven read-modify-write,
// then PLL reset release and lock wait with timeouts.
module plle2_drp_sequencer #(
  parameter int NUM_ENTRIES  = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_START,
  output logic [3:0]  O_TBL_IDX,
  input  logic [38:0] I_TBL_ENTRY,
  output logic        O_DEN,
  output logic        O_DWE,
  output logic [6:0]  O_DADDR,
  output logic [15:0] O_DI,
  input  logic [15:0] I_DO,
  input  logic        I_DRDY,
  output logic        O_PLL_RST,
  input  logic        I_LOCKED,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_ERROR,
  output logic [1:0]  O_ERR_CODE
);

  localparam int MAXT = (DRDY_TIMEOUT > LOCK_TIMEOUT) ?
                        DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW = $clog2(MAXT + 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0] IDX_LAST = 4'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ASSERT, S_RD, S_RDW, S_WR,
    S_WRW, S_RELEASE, S_LOCKW, S_DONE, S_ERROR
  } state_t;

  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic den_q, den_d;
  logic dwe_q, dwe_d;
  logic [6:0] daddr_q, daddr_d;
  logic [15:0] di_q, di_d;
  logic pll_rst_q, pll_rst_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic [1:0] err_code_q, err_code_d;

  logic [6:0] e_daddr;
  logic [15:0] e_mask;
  logic [15:0] e_data;

  assign e_daddr = I_TBL_ENTRY[38:32];
  assign e_mask = I_TBL_ENTRY[31:16];
  assign e_data = I_TBL_ENTRY[15:0];

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    last_d = last_q;
    cnt_d = '0;
    den_d = 1'b0;
    dwe_d = 1'b0;
    daddr_d = daddr_q;
    di_d = di_q;
    pll_rst_d = pll_rst_q;
    busy_d = busy_q;
    done_d = done_q;
    error_d = error_q;
    err_code_d = err_code_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (I_START) begin
          state_d = S_ASSERT;
          idx_d = '0;
          done_d = 1'b0;
          error_d = 1'b0;
          err_code_d = 2'd0;
          busy_d = 1'b1;
          pll_rst_d = 1'b1;
        end
      end
      S_ASSERT: begin
        state_d = S_RD;
        den_d = 1'b1;
        daddr_d = e_daddr;
      end
      S_RD: state_d = S_RDW;
      S_RDW: begin
        if (I_DRDY) begin
          state_d = S_WR;
          den_d = 1'b1;
          dwe_d = 1'b1;
          daddr_d = e_daddr;
          di_d = (I_DO & e_mask) | (e_data & ~e_mask);
        end else if (cnt_q == DRDY_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d = 1'b0;
          err_code_d = 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        // Advance the index early so the next entry is on the
        // table read port by the time RD is entered.
        state_d = S_WRW;
        last_d = (idx_q == IDX_LAST);
        if (idx_q != IDX_LAST) idx_d = idx_q + 4'd1;
      end
      S_WRW: begin
        if (I_DRDY) begin
          if (last_q) begin
            state_d = S_RELEASE;
            pll_rst_d = 1'b0;
          end else begin
            state_d = S_RD;
            den_d = 1'b1;
            daddr_d = e_daddr;
          end
        end else if (cnt_q == DRDY_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d = 1'b0;
          err_code_d = 2'd2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: state_d = S_LOCKW;
      S_LOCKW: begin
        if (I_LOCKED) begin
          state_d = S_DONE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d = 1'b0;
          err_code_d = 2'd3;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      den_q <= 1'b0;
      dwe_q <= 1'b0;
      daddr_q <= '0;
      di_q <= '0;
      pll_rst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      den_q <= den_d;
      dwe_q <= dwe_d;
      daddr_q <= daddr_d;
      di_q <= di_d;
      pll_rst_q <= pll_rst_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign O_TBL_IDX = idx_q;
  assign O_DEN = den_q;
  assign O_DWE = dwe_q;
  assign O_DADDR = daddr_q;
  assign O_DI = di_q;
  assign O_PLL_RST = pll_rst_q;
  assign O_BUSY = busy_q;
  assign O_DONE = done_q;
  assign O_ERROR = error_q;
  assign O_ERR_CODE = err_code_q;

endmodule
